// File: rtl/fpu_pkg.sv
// fpu_pkg: shared state encoding, field widths and FP32 constants for the sequential multiplier.
package fpu_pkg;
    typedef enum logic [2:0] {IDLE, UNPACK, MULT, NORM, ROUND, OUT_ARM, OUT_HOLD} FpMulState;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int SIG_W = 24;
    localparam int PROD_W = 48;
    localparam int EXP_BIAS = 127;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;
endpackage

// File: rtl/mant_seq_mul.sv
// mant_seq_mul: iterative shift-add 24x24 significand multiplier, RADIX_BITS multiplier bits per cycle.
module mant_seq_mul
    import fpu_pkg::*;
#(
    parameter int RADIX_BITS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SIG_W-1:0]  a,
    input  logic [SIG_W-1:0]  b,
    output logic              done,
    output logic [PROD_W-1:0] prod
);
    localparam int STEPS = SIG_W / RADIX_BITS;
    localparam int CW = $clog2(STEPS);
    logic              busy;
    logic [CW-1:0]     step;
    logic [PROD_W-1:0] mcand;
    logic [PROD_W-1:0] partial;
    logic [SIG_W-1:0]  mplier;
    always_comb begin
        partial = '0;
        for (int i = 0; i < RADIX_BITS; i++)
            partial = mplier[i] ? partial + (mcand << i) : partial;
    end
    // done is high during the final step; prod is complete after that edge
    assign done = busy && step == CW'(STEPS - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            step   <= '0;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            step   <= '0;
            prod   <= '0;
            mcand  <= {{(PROD_W - SIG_W){1'b0}}, a};
            mplier <= b;
        end else if (busy) begin
            busy   <= !done;
            step   <= step + 1'b1;
            prod   <= prod + partial;
            mcand  <= mcand << RADIX_BITS;
            mplier <= mplier >> RADIX_BITS;
        end
    end
endmodule

// File: rtl/fp32_seq_multiplier.sv
// fp32_seq_multiplier: multi-cycle FP32 multiplier with RNE rounding, DAZ/FTZ, and a valid/ACK result hold.
module fp32_seq_multiplier
    import fpu_pkg::*;
#(
    parameter int RADIX_BITS = 1
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        In_valid,
    output logic        In_ready,
    output logic [31:0] Data,
    output logic        Data_valid,
    input  logic        ACK
);
    FpMulState          state, state_nxt;
    logic [31:0]        a_r, b_r;
    logic [PROD_W-2:0]  prod_n;
    logic signed [9:0]  exp_n;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   fa, fb;
    logic               sign, zero_any, inf_any, nan_any, special, accept, mul_start, mul_done;
    logic [31:0]        special_res, round_res;
    logic [PROD_W-1:0]  prod;
    logic [PROD_W-2:0]  prod_norm;
    logic signed [9:0]  exp_sum, exp_norm, exp_r;
    logic [SIG_W-1:0]   mant;
    logic [SIG_W:0]     m25;
    logic               round_up;

    assign ea = a_r[30:23];
    assign eb = b_r[30:23];
    assign fa = a_r[22:0];
    assign fb = b_r[22:0];
    assign sign = a_r[31] ^ b_r[31];
    // denormal inputs count as zero
    assign zero_any = ea == '0 || eb == '0;
    assign inf_any = (&ea && fa == '0) || (&eb && fb == '0);
    assign nan_any = (&ea && |fa) || (&eb && |fb);
    assign special = zero_any || inf_any || nan_any;
    assign special_res = (nan_any || (inf_any && zero_any)) ? QNAN :
                         inf_any ? {sign, POS_INF[30:0]} : {sign, 31'b0};

    mant_seq_mul #(.RADIX_BITS(RADIX_BITS)) u_mul (
        .clk(CLK),
        .rst_n(RSTN),
        .start(mul_start),
        .a({|ea, fa}),
        .b({|eb, fb}),
        .done(mul_done),
        .prod(prod)
    );

    // a dropped bit on the right shift is folded into the sticky position
    assign exp_sum = $signed({2'b0, ea}) + $signed({2'b0, eb}) - 10'(EXP_BIAS);
    assign exp_norm = exp_sum + $signed({9'b0, prod[PROD_W-1]});
    assign prod_norm = prod[PROD_W-1] ? {prod[PROD_W-1:2], |prod[1:0]} : prod[PROD_W-2:0];

    assign mant = prod_n[46:23];
    assign round_up = prod_n[22] && (|prod_n[21:0] || mant[0]);
    assign m25 = {1'b0, mant} + {{SIG_W{1'b0}}, round_up};
    assign exp_r = exp_n + $signed({9'b0, m25[SIG_W]});
    assign round_res = exp_r >= 10'sd255 ? {sign, POS_INF[30:0]} :
                       exp_r <= 10'sd0 ? {sign, 31'b0} : {sign, exp_r[7:0], m25[22:0]};

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = In_valid ? UNPACK : IDLE;
            UNPACK:   state_nxt = special ? OUT_ARM : MULT;
            MULT:     state_nxt = mul_done ? NORM : MULT;
            NORM:     state_nxt = ROUND;
            ROUND:    state_nxt = OUT_ARM;
            OUT_ARM:  state_nxt = OUT_HOLD;
            OUT_HOLD: state_nxt = ACK ? IDLE : OUT_HOLD;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        In_ready = state == IDLE;
        accept = In_valid && In_ready;
        mul_start = state == UNPACK && !special;
    end

    // ACK seen during OUT_ARM may be stale from the previous pass, so only OUT_HOLD releases
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            a_r        <= '0;
            b_r        <= '0;
            prod_n     <= '0;
            exp_n      <= '0;
            Data       <= '0;
            Data_valid <= 1'b0;
        end else begin
            if (accept) begin
                a_r <= A;
                b_r <= B;
            end
            if (state == NORM) begin
                prod_n <= prod_norm;
                exp_n  <= exp_norm;
            end
            if (state == UNPACK && special) Data <= special_res;
            else if (state == ROUND) Data <= round_res;
            Data_valid <= state == OUT_ARM || (state == OUT_HOLD && !ACK);
        end
    end
endmodule

// File: tb/tb_fp32_seq_multiplier.sv
// tb_fp32_seq_multiplier: directed vectors over four instances (RADIX_BITS 1,2,4,8).
module tb_fp32_seq_multiplier;
    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [3:0]  iv = '0;
    logic [3:0]  ack = '0;
    logic [3:0]  rdy;
    logic [3:0]  dv;
    logic [31:0] data [4];
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 4; g++) begin : u
        fp32_seq_multiplier #(.RADIX_BITS(1 << g)) dut (
            .CLK(CLK),
            .RSTN(RSTN),
            .A(A),
            .B(B),
            .In_valid(iv[g]),
            .In_ready(rdy[g]),
            .Data(data[g]),
            .Data_valid(dv[g]),
            .ACK(ack[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // accept one op on unit k, hold In_valid one extra cycle and scramble A/B after accept
    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input int lat, input bit early_ack);
        int cnt = 0;
        string t = $sformatf("u%0d %h*%h", k, a, b);
        check({t, " ready"}, 32'(rdy[k]), 32'd1);
        A = a;
        B = b;
        iv[k] = 1'b1;
        @(posedge CLK);
        #1;
        A = 32'hDEADBEEF;
        B = ~b;
        do begin
            @(posedge CLK);
            #1;
            cnt++;
            if (cnt == 1) begin
                iv[k] = 1'b0;
                check({t, " busy"}, 32'(rdy[k]), 32'd0);
            end
            if (early_ack && cnt == lat - 1) ack[k] = 1'b1;
        end while (!dv[k] && cnt < 200);
        ack[k] = 1'b0;
        check({t, " latency"}, 32'(cnt), 32'(lat));
        check({t, " data"}, data[k], res);
        @(posedge CLK);
        #1;
        check({t, " hold valid"}, 32'(dv[k]), 32'd1);
        check({t, " hold data"}, data[k], res);
        ack[k] = 1'b1;
        @(posedge CLK);
        #1;
        ack[k] = 1'b0;
        check({t, " released"}, 32'(dv[k]), 32'd0);
        check({t, " idle"}, 32'(rdy[k]), 32'd1);
        check({t, " kept"}, data[k], res);
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("u%0d reset ready", k), 32'(rdy[k]), 32'd1);
            check($sformatf("u%0d reset valid", k), 32'(dv[k]), 32'd0);
            check($sformatf("u%0d reset data", k), data[k], 32'd0);
        end
        RSTN = 1'b1;
        @(posedge CLK);
        #1;
        run_op(0, 32'h3FC00000, 32'h40000000, 32'h40400000, 28, 0);
        run_op(0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 2, 0);
        run_op(0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 2, 0);
        run_op(0, 32'hFF800000, 32'h40000000, 32'hFF800000, 2, 0);
        run_op(0, 32'h80000000, 32'h3F800000, 32'h80000000, 2, 0);
        run_op(0, 32'h007FFFFF, 32'h7F800000, 32'h7FC00000, 2, 0);
        run_op(0, 32'h3F800000, 32'h00000001, 32'h00000000, 2, 0);
        run_op(0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 28, 0);
        run_op(0, 32'h00800000, 32'h00800000, 32'h00000000, 28, 0);
        run_op(0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 28, 0);
        // (1+2^-23)*(2-2^-22) = 2-2^-45: rounds up with mantissa carry-out to 2.0
        run_op(0, 32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 28, 0);
        run_op(0, 32'h3FC00000, 32'h3F800001, 32'h3FC00002, 28, 0);
        run_op(0, 32'h3FC00000, 32'h3F800003, 32'h3FC00004, 28, 0);
        run_op(0, 32'hC0000000, 32'h3FC00000, 32'hC0400000, 28, 0);
        run_op(0, 32'h40400000, 32'h40400000, 32'h41100000, 28, 1);
        run_op(0, 32'h7F800000, 32'h7F800000, 32'h7F800000, 2, 1);
        A = 32'h3FC00000;
        B = 32'h40000000;
        iv[0] = 1'b1;
        @(posedge CLK);
        #1;
        iv[0] = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        RSTN = 1'b0;
        #1;
        check("abort valid", 32'(dv[0]), 32'd0);
        check("abort ready", 32'(rdy[0]), 32'd1);
        check("abort data", data[0], 32'd0);
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        @(posedge CLK);
        #1;
        run_op(0, 32'h3FC00000, 32'h40000000, 32'h40400000, 28, 0);
        for (int k = 0; k < 4; k++) begin
            run_op(k, 32'h3FC00000, 32'h40000000, 32'h40400000, 4 + (24 >> k), 0);
            run_op(k, 32'h3FC00000, 32'h3F800001, 32'h3FC00002, 4 + (24 >> k), 0);
            run_op(k, 32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 4 + (24 >> k), 1);
            run_op(k, 32'h7F800000, 32'hC0000000, 32'hFF800000, 2, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
